pc_gen_way0: RTL and testbench
==============================

# pc_gen_way0

Program-counter and fetch-request generator for way 0, directly upstream of the way-0 instruction fetch unit. It holds the way-0 PC, presents one fetch address per cycle under a valid/ready handshake, and limits outstanding memory requests. It redirects on a jump and marks stale in-flight responses for discard until they have drained.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, first way-0 fetch address after reset.
- PC_STEP, 8, byte increment per accepted request (way 0 fetches every other word).
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered requests (1..3).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ready_i  in  1  fetch unit can accept a request this cycle.
- dataOk_i  in  1  memory returned data for the oldest outstanding request.
- jumpFlag_i  in  1  redirect pulse from the back end.
- jumpAddr_i  in  32  redirect target.
- valid_o  out  1  instAddr_o is a valid fetch request.
- instAddr_o  out  32  current way-0 PC.
- discard_o  out  1  the current dataOk_i response is stale and must be dropped.
- outstanding_o  out  2  count of in-flight requests.

## Operation
- State machine: BOOT, RUN, DRAIN.
  - BOOT: entered on reset; lasts exactly one cycle; then RUN.
  - RUN: normal issue.
  - DRAIN: waiting for stale responses after a redirect.
- Issue:
  - valid_o = (state==RUN) && !jumpFlag_i && (outstanding < MAX_OUTSTANDING). valid_o is combinational.
  - A request is accepted on valid_o && ready_i.
  - On accept: pc <= pc + PC_STEP, mod 2^32; wrap from 32'hFFFF_FFF8 to 0 is silent.
- Outstanding counter:
  - +1 on accept, -1 on dataOk_i; both in the same cycle leaves it unchanged.
  - dataOk_i with outstanding==0 is ignored; the counter saturates at 0.
- Redirect (jumpFlag_i high, any state other than BOOT):
  - pc <= {jumpAddr_i[31:2], 2'b00}.
  - Any accept in that cycle is suppressed, because valid_o is low.
  - Let n = outstanding minus dataOk_i for that cycle.
  - If n > 0: next state is DRAIN, and stale_cnt <= n.
  - If n == 0: next state is RUN.
- DRAIN:
  - valid_o = 0; discard_o = dataOk_i.
  - Each dataOk_i decrements both stale_cnt and outstanding.
  - When stale_cnt reaches 0, go to RUN on the next cycle.
  - A further jump in DRAIN overwrites pc and keeps the current stale_cnt.
- discard_o is 0 in RUN and BOOT.
- A jump in BOOT is ignored; the PC starts at RESET_PC regardless.

## Timing
- Reset values:
  - state = BOOT
  - pc/instAddr_o = RESET_PC
  - outstanding_o = 0
  - stale_cnt = 0
  - valid_o = 0
  - discard_o = 0
- First valid_o: the second rising edge after reset deasserts (one BOOT cycle).
- Throughput: one accept per cycle while ready_i is high and the outstanding limit is not reached.
- Redirect latency: the new PC appears on instAddr_o the cycle after jumpFlag_i. It is requested in that cycle if the drain is complete; otherwise it is requested the cycle after the last stale dataOk_i.
- reset asserted at any time, including mid-DRAIN, returns all state to reset values immediately. Responses arriving after reset are not tracked.

## Test plan
- Reset then ready_i=1 and dataOk_i one cycle after each accept -> addresses 8000_0000, 8000_0008, 8000_0010 on consecutive accepts; outstanding_o toggles between 1 and 0 (or holds at 1); no discard_o.
- ready_i=1 with no dataOk_i -> exactly 2 accepts (…00, …08), then valid_o=0 with outstanding_o=2; one dataOk_i -> valid_o returns the next cycle with …10.
- Two requests outstanding, jumpFlag_i with jumpAddr_i=0000_1003 -> instAddr_o=0000_1000 the next cycle, valid_o=0; next two dataOk_i pulses each raise discard_o; valid_o returns after the second with 0000_1000.
- Jump in the same cycle as dataOk_i, with outstanding=1 -> n=0; discard_o=0; RUN is kept; the new PC is requested the next cycle.
- Second jump mid-DRAIN (jumpAddr_i=0000_2000) -> pc=0000_2000; the drain still completes after the remaining stale responses; the first request issued is 0000_2000.
- Reset asserted mid-DRAIN -> same cycle: valid_o=0, outstanding_o=0, instAddr_o=8000_0000; after release, one BOOT cycle then normal issue.

Source files
------------

// File: rtl/pc_gen_way0.sv
// pc_gen_way0: way-0 program counter and fetch-request generator.
// Issues one fetch address per cycle under a valid/ready handshake, caps the
// number of in-flight memory requests, and after a redirect flags the stale
// responses of the old path for discard until they have drained.
module pc_gen_way0 #(
   parameter logic [31:0] RESET_PC        = 32'h8000_0000,
   parameter logic [31:0] PC_STEP         = 32'd8,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ready_i,
   input  logic        dataOk_i,
   input  logic        jumpFlag_i,
   input  logic [31:0] jumpAddr_i,
   output logic        valid_o,
   output logic [31:0] instAddr_o,
   output logic        discard_o,
   output logic [1:0]  outstanding_o
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [1:0] MAX_OUT = 2'(MAX_OUTSTANDING);

   state_t      state;
   logic [31:0] pc;
   logic [1:0]  outstanding;
   logic [1:0]  stale_cnt;

   logic        accept;
   logic        resp;
   logic [1:0]  out_after_resp;
   logic [31:0] jump_target;

   // The target is forced word aligned; its low two bits are deliberately dropped.
   logic        unused_jump_lsb;
   assign unused_jump_lsb = ^jumpAddr_i[1:0];

   // Handshake, response bookkeeping and redirect target decoding.
   always_comb begin
      valid_o        = (state == RUN) && !jumpFlag_i && (outstanding < MAX_OUT);
      accept         = valid_o && ready_i;
      // A response with nothing in flight is not ours to count.
      resp           = dataOk_i && (outstanding != 2'd0);
      out_after_resp = outstanding - {1'b0, resp};
      discard_o      = (state == DRAIN) && dataOk_i;
      jump_target    = {jumpAddr_i[31:2], 2'b00};
   end

   assign instAddr_o    = pc;
   assign outstanding_o = outstanding;

   // Sequencer: BOOT lasts one cycle, RUN issues, DRAIN waits out stale responses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= BOOT;
         pc          <= RESET_PC;
         outstanding <= 2'd0;
         stale_cnt   <= 2'd0;
      end else begin
         outstanding <= out_after_resp + {1'b0, accept};
         case (state)
            BOOT: begin
               // A redirect here is ignored; the first fetch is always RESET_PC.
               state <= RUN;
            end
            RUN: begin
               if (jumpFlag_i) begin
                  pc <= jump_target;
                  // Whatever is still in flight after this cycle's response belongs
                  // to the abandoned path.
                  if (out_after_resp != 2'd0) begin
                     state     <= DRAIN;
                     stale_cnt <= out_after_resp;
                  end
               end else if (accept) begin
                  pc <= pc + PC_STEP;
               end
            end
            DRAIN: begin
               // A further redirect only moves the PC; the stale count is unaffected.
               if (jumpFlag_i) begin
                  pc <= jump_target;
               end
               if (stale_cnt == 2'd0) begin
                  state <= RUN;
               end else if (resp) begin
                  stale_cnt <= stale_cnt - 2'd1;
                  if (stale_cnt == 2'd1) begin
                     state <= RUN;
                  end
               end
            end
            default: begin
               state     <= BOOT;
               stale_cnt <= 2'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_gen_way0.sv
// tb_pc_gen_way0: directed scenarios plus randomized traffic for pc_gen_way0,
// compared every cycle against a queue-based model of the in-flight requests.
module tb_pc_gen_way0;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;
   localparam int          MAX_OUT  = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        ready_i;
   logic        dataOk_i;
   logic        jumpFlag_i;
   logic [31:0] jumpAddr_i;
   logic        valid_o;
   logic [31:0] instAddr_o;
   logic        discard_o;
   logic [1:0]  outstanding_o;

   pc_gen_way0 #(
      .RESET_PC       (RESET_PC),
      .PC_STEP        (32'd8),
      .MAX_OUTSTANDING(MAX_OUT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .ready_i      (ready_i),
      .dataOk_i     (dataOk_i),
      .jumpFlag_i   (jumpFlag_i),
      .jumpAddr_i   (jumpAddr_i),
      .valid_o      (valid_o),
      .instAddr_o   (instAddr_o),
      .discard_o    (discard_o),
      .outstanding_o(outstanding_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: one queue entry per in-flight request, flagged when it belongs to an
   // abandoned path. Draining simply means some flagged entry is still in flight.
   bit          m_boot;
   logic [31:0] m_pc;
   bit          m_q[$];
   logic [31:0] acc_log[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_draining();
      foreach (m_q[i]) if (m_q[i]) return 1'b1;
      return 1'b0;
   endfunction

   // One clock cycle: apply inputs, compare outputs against the model, advance the model.
   task automatic step(input bit rdy, input bit dok, input bit jmp, input logic [31:0] ja);
      bit          exp_v;
      bit          exp_d;
      bit          was_boot;
      @(negedge clk);
      ready_i    = rdy;
      dataOk_i   = dok;
      jumpFlag_i = jmp;
      jumpAddr_i = ja;
      #1;
      exp_v = !m_boot && !m_draining() && !jmp && (m_q.size() < MAX_OUT);
      exp_d = m_draining() && dok;
      check("valid", 32'(valid_o), 32'(exp_v));
      check("addr", instAddr_o, m_pc);
      check("discard", 32'(discard_o), 32'(exp_d));
      check("outstanding", 32'(outstanding_o), 32'(m_q.size()));
      if (valid_o && ready_i) acc_log.push_back(instAddr_o);
      @(posedge clk);
      was_boot = m_boot;
      m_boot   = 1'b0;
      if (dok && m_q.size() > 0) void'(m_q.pop_front());
      if (!was_boot && jmp) begin
         m_pc = {ja[31:2], 2'b00};
         foreach (m_q[i]) m_q[i] = 1'b1;
      end else if (exp_v && rdy) begin
         m_q.push_back(1'b0);
         m_pc = m_pc + 32'd8;
      end
   endtask

   // Asynchronous reset; outputs must return to reset values without a clock edge.
   task automatic reset_dut();
      @(negedge clk);
      reset      = 1'b1;
      ready_i    = 1'b0;
      dataOk_i   = 1'b0;
      jumpFlag_i = 1'b0;
      jumpAddr_i = 32'h0;
      #1;
      check("rst_valid", 32'(valid_o), 32'd0);
      check("rst_addr", instAddr_o, RESET_PC);
      check("rst_outstanding", 32'(outstanding_o), 32'd0);
      check("rst_discard", 32'(discard_o), 32'd0);
      m_q.delete();
      m_pc   = RESET_PC;
      m_boot = 1'b1;
      @(posedge clk);
      #2 reset = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      ready_i    = 1'b0;
      dataOk_i   = 1'b0;
      jumpFlag_i = 1'b0;
      jumpAddr_i = 32'h0;

      // Streaming with a response one cycle after each accept.
      reset_dut();
      acc_log.delete();
      step(1, 0, 1, 32'h1234_0000);  // boot cycle, jump ignored
      step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      check("stream0", acc_log[0], 32'h8000_0000);
      check("stream1", acc_log[1], 32'h8000_0008);
      check("stream2", acc_log[2], 32'h8000_0010);

      // Outstanding limit, then one response reopens issue.
      reset_dut();
      acc_log.delete();
      step(1, 0, 0, 0);
      repeat (4) step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      step(1, 0, 0, 0);
      check("limit_count", 32'(acc_log.size()), 32'd3);
      check("limit_next", acc_log[2], 32'h8000_0010);

      // Redirect with two in flight: two discards, then the target is requested.
      acc_log.delete();
      step(0, 0, 1, 32'h0000_1003);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      step(1, 0, 0, 0);
      check("drain_target", acc_log[0], 32'h0000_1000);

      // Redirect coinciding with the only response: no drain.
      acc_log.delete();
      step(0, 1, 1, 32'h0000_5000);
      step(1, 0, 0, 0);
      check("jump_ok_target", acc_log[0], 32'h0000_5000);

      // Second redirect while draining.
      step(1, 0, 0, 0);
      step(0, 0, 1, 32'h0000_3000);
      step(0, 1, 1, 32'h0000_2000);
      step(0, 1, 0, 0);
      acc_log.delete();
      step(1, 0, 0, 0);
      check("rejump_target", acc_log[0], 32'h0000_2000);

      // Reset in the middle of a drain.
      step(1, 0, 0, 0);
      step(0, 0, 1, 32'h0000_7000);
      reset_dut();
      acc_log.delete();
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      check("post_reset_first", acc_log[0], RESET_PC);

      // Address wrap at the top of the space.
      step(0, 1, 1, 32'hFFFF_FFFB);
      acc_log.delete();
      step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      check("wrap_hi", acc_log[0], 32'hFFFF_FFF8);
      check("wrap_lo", acc_log[1], 32'h0000_0000);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         if (i % 600 == 599) reset_dut();
         else step(($urandom % 4) != 0, ($urandom % 3) == 0,
                   ($urandom % 12) == 0, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
